// File: rtl/issue_queue_checkpoint_table_pkg.sv
// issue_queue_checkpoint_table_pkg: sizes, types and age/pick helpers for the checkpoint table
package issue_queue_checkpoint_table_pkg;
  localparam int CP_COUNT = 4;
  localparam int CP_AW = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int PICK_W = 4;
  typedef logic [FIFO_DEPTH:0] snap_t;
  typedef logic [CP_AW-1:0] cp_id_t;
  typedef logic [CP_AW:0] cp_cnt_t;
  typedef logic [PICK_W-1:0] pick_t;
  function automatic cp_id_t age(cp_id_t id, cp_id_t head);
    return id - head;
  endfunction
  function automatic int picked_below(pick_t m, int k);
    int n = 0;
    for (int i = 0; i < PICK_W; i++) n += (i < k && m[i]) ? 1 : 0;
    return n;
  endfunction
endpackage

// File: rtl/issue_queue_checkpoint_table_if.sv
// issue_queue_checkpoint_table_if: alloc/recover/commit/pick bundle between issue logic and checkpoint table
interface issue_queue_checkpoint_table_if;
  import issue_queue_checkpoint_table_pkg::*;
  logic snoop_hit, alloc_valid, alloc_ready, recover_valid, recover_out_valid, commit_valid, full, empty;
  snap_t alloc_fifo_pr, recover_fifo_pr;
  cp_id_t alloc_id, recover_id;
  pick_t pick_mask;
  cp_cnt_t count;
  modport master (
    output snoop_hit, alloc_valid, alloc_fifo_pr, recover_valid, recover_id, commit_valid, pick_mask,
    input alloc_ready, alloc_id, recover_out_valid, recover_fifo_pr, full, empty, count
  );
  modport slave (
    input snoop_hit, alloc_valid, alloc_fifo_pr, recover_valid, recover_id, commit_valid, pick_mask,
    output alloc_ready, alloc_id, recover_out_valid, recover_fifo_pr, full, empty, count
  );
endinterface

// File: rtl/iq_cp_ptr_shift.sv
// iq_cp_ptr_shift: moves a one-hot FIFO position down by the number of picked slots beneath it
module iq_cp_ptr_shift
  import issue_queue_checkpoint_table_pkg::*;
(
  input  snap_t snap_in,
  input  pick_t pick_mask,
  output snap_t snap_out
);
  always_comb begin
    snap_out = '0;
    for (int k = 0; k <= FIFO_DEPTH; k++)
      for (int j = k; j <= FIFO_DEPTH; j++)
        snap_out[k] = snap_out[k] | (snap_in[j] && (j - picked_below(pick_mask, j) == k));
  end
endmodule

// File: rtl/issue_queue_checkpoint_table.sv
// issue_queue_checkpoint_table: circular table of one-hot issue-FIFO tail snapshots, one per in-flight branch
module issue_queue_checkpoint_table
  import issue_queue_checkpoint_table_pkg::*;
(
  input logic clk,
  input logic reset,
  issue_queue_checkpoint_table_if.slave bus
);
  localparam logic [CP_COUNT-1:0] ONE = 1;
  logic [CP_COUNT-1:0] valid, younger;
  snap_t snap [CP_COUNT];
  snap_t snap_sh [CP_COUNT];
  snap_t alloc_sh;
  cp_id_t head, tail;
  cp_cnt_t count;
  logic full, empty, rec, cmt, alc;
  for (genvar e = 0; e < CP_COUNT; e++) begin : g_sh
    iq_cp_ptr_shift u_sh (.snap_in(snap[e]), .pick_mask(bus.pick_mask), .snap_out(snap_sh[e]));
  end
  iq_cp_ptr_shift u_alloc_sh (.snap_in(bus.alloc_fifo_pr), .pick_mask(bus.pick_mask), .snap_out(alloc_sh));
  assign full = count == cp_cnt_t'(CP_COUNT);
  assign empty = count == '0;
  assign rec = bus.recover_valid && valid[bus.recover_id];
  assign cmt = bus.commit_valid && !empty && !(rec && bus.recover_id == head);
  // a commit frees the slot in the same cycle, so alloc at full is allowed alongside it
  assign alc = bus.alloc_valid && !bus.snoop_hit && !rec && (!full || cmt);
  always_comb begin
    younger = '0;
    for (int i = 0; i < CP_COUNT; i++)
      younger[i] = rec && age(cp_id_t'(i), head) >= age(bus.recover_id, head);
  end
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.count = count;
  assign bus.alloc_ready = !full;
  assign bus.alloc_id = tail;
  assign bus.recover_out_valid = valid[bus.recover_id];
  assign bus.recover_fifo_pr = snap[bus.recover_id];
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < CP_COUNT; i++) snap[i] <= '0;
    end else begin
      for (int i = 0; i < CP_COUNT; i++) snap[i] <= (alc && cp_id_t'(i) == tail) ? alloc_sh : snap_sh[i];
      if (bus.snoop_hit) begin
        valid <= '0;
        head <= '0;
        tail <= '0;
        count <= '0;
      end else begin
        valid <= (valid & ~younger & ~(cmt ? ONE << head : '0)) | (alc ? ONE << tail : '0);
        head <= head + cp_id_t'(cmt);
        tail <= rec ? bus.recover_id : tail + cp_id_t'(alc);
        count <= rec ? cp_cnt_t'(age(bus.recover_id, head)) - cp_cnt_t'(cmt)
                     : count + cp_cnt_t'(alc) - cp_cnt_t'(cmt);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && !bus.snoop_hit && bus.recover_valid) begin
      assert (valid[bus.recover_id]);
      assert (!(bus.commit_valid && bus.recover_id == head));
    end
  end
endmodule
